// File: rtl/vector_memory_responder_if.sv
// Load/write bus between processing_block (master) and vector_memory_responder (slave).
// Carries the load request/return path and the write commit path; clock and reset stay outside.
interface vector_memory_responder_if #(
   parameter int W = 512
);
   logic [15:0]  load_addr;
   logic         load_ctrl;
   logic [W-1:0] load_data;
   logic         load_valid;
   logic [15:0]  write_addr;
   logic [W-1:0] write_data;
   logic         write_ctrl;
   logic         addr_error;

   modport master (
      output load_addr, load_ctrl, write_addr, write_data, write_ctrl,
      input  load_data, load_valid, addr_error
   );

   modport slave (
      input  load_addr, load_ctrl, write_addr, write_data, write_ctrl,
      output load_data, load_valid, addr_error
   );
endinterface

// File: rtl/vector_memory_responder.sv
// Main-memory responder: vector loads through a fixed-latency read pipeline, vector writes committed at once.
// Optional MEM_STATS_EN adds load_count/write_count statistics ports.
module vector_memory_responder #(
   parameter int W            = 512,
   parameter int DEPTH        = 1024,
   parameter int LOAD_LATENCY = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   vector_memory_responder_if.slave  bus
`ifdef MEM_STATS_EN
   ,
   output logic [31:0]               load_count,
   output logic [31:0]               write_count
`endif
);

   // Handshake: there is no ready. A ctrl strobe high at a rising edge is a complete
   // request and is always accepted; load_valid is a one-cycle strobe the master must take.
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0] mem [DEPTH];

   logic         load_in_range;
   logic         write_in_range;
   logic         load_accept;
   logic         write_commit;
   logic         write_oob;
   logic [W-1:0] rd_word;

   logic         s_valid;
   logic         s_err;
   logic [W-1:0] s_data;

   logic         out_valid;
   logic         out_err;
   logic [W-1:0] out_data;

   assign load_in_range  = 32'(bus.load_addr) < DEPTH;
   assign write_in_range = 32'(bus.write_addr) < DEPTH;
   assign load_accept    = bus.load_ctrl && !reset;
   assign write_commit   = bus.write_ctrl && write_in_range && !reset;
   assign write_oob      = bus.write_ctrl && !write_in_range && !reset;

   // Read happens at the sample edge; a same-edge write to the same word wins.
   always_comb begin
      rd_word = '0;
      if (load_in_range) begin
         if (write_commit && (bus.write_addr == bus.load_addr)) begin
            rd_word = bus.write_data;
         end else begin
            rd_word = mem[bus.load_addr[AW-1:0]];
         end
      end
   end

   // Array contents survive reset by design.
   always_ff @(posedge clock) begin
      if (write_commit) begin
         mem[bus.write_addr[AW-1:0]] <= bus.write_data;
      end
   end

   assign s_valid = load_accept;
   assign s_err   = load_accept && !load_in_range;
   assign s_data  = rd_word;

   generate
      if (LOAD_LATENCY <= 1) begin : g_direct
         assign out_valid = s_valid;
         assign out_err   = s_err;
         assign out_data  = s_data;
      end else begin : g_pipe
         logic         pv [LOAD_LATENCY-1];
         logic         pe [LOAD_LATENCY-1];
         logic [W-1:0] pd [LOAD_LATENCY-1];

         always_ff @(posedge clock) begin
            if (reset) begin
               for (int i = 0; i < LOAD_LATENCY - 1; i++) begin
                  pv[i] <= 1'b0;
                  pe[i] <= 1'b0;
               end
            end else begin
               pv[0] <= s_valid;
               pe[0] <= s_err;
               for (int i = 1; i < LOAD_LATENCY - 1; i++) begin
                  pv[i] <= pv[i-1];
                  pe[i] <= pe[i-1];
               end
            end
         end

         // Data needs no reset: it is only consumed alongside its valid bit.
         always_ff @(posedge clock) begin
            pd[0] <= s_data;
            for (int i = 1; i < LOAD_LATENCY - 1; i++) begin
               pd[i] <= pd[i-1];
            end
         end

         assign out_valid = pv[LOAD_LATENCY-2];
         assign out_err   = pe[LOAD_LATENCY-2];
         assign out_data  = pd[LOAD_LATENCY-2];
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         bus.load_valid <= 1'b0;
         bus.load_data  <= '0;
         bus.addr_error <= 1'b0;
      end else begin
         bus.load_valid <= out_valid;
         if (out_valid) begin
            bus.load_data <= out_data;
         end
         bus.addr_error <= (out_valid && out_err) || write_oob;
      end
   end

`ifdef MEM_STATS_EN
   // Out-of-range loads still count as accepted; out-of-range writes are never committed.
   always_ff @(posedge clock) begin
      if (reset) begin
         load_count  <= '0;
         write_count <= '0;
      end else begin
         if (load_accept) begin
            load_count <= load_count + 32'd1;
         end
         if (write_commit) begin
            write_count <= write_count + 32'd1;
         end
      end
   end
`endif

endmodule
